// File: rtl/cg_pkg.sv
// Shared definitions for the CG address sequencer: sequencer states,
// drain length and default parameter values.
package cg_pkg;

    localparam int CG_NUM_UNITS = 8;
    localparam int CG_NUM_CH    = 4;
    localparam int CG_ADDR_W    = 32;
    localparam int CG_ITER_W    = 11;

    // Cycles spent flushing the pipeline between two CG iterations
    localparam int DRAIN_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALT    = 3'd4
    } cg_state_e;

endpackage : cg_pkg

// File: rtl/cg_wrap_counter.sv
// Address counter that advances on enable, returns to 0 after reaching
// limit_i and pulses wrap_o in the cycle the wrapped value 0 is visible.
module cg_wrap_counter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              wrap_o
);

    logic [ADDR_W-1:0] count_q, count_d;
    logic              wrap_q, wrap_d;

    // Next count: clear beats enable; >= keeps the counter bounded if the
    // limit ever shrinks below the current count
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q >= limit_i) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + ADDR_W'(1);
            end
        end
    end

    // Count and wrap-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule : cg_wrap_counter

// File: rtl/cg_addr_sequencer.sv
// Address sequencer for a conjugate-gradient vector engine: sizes the
// vectors in memory words, streams the A-matrix preload, and keeps per-
// channel read/write addresses that restart on every iteration.
module cg_addr_sequencer
    import cg_pkg::*;
#(
    parameter int NUM_UNITS = CG_NUM_UNITS,
    parameter int NUM_CH    = CG_NUM_CH,
    parameter int ADDR_W    = CG_ADDR_W,
    parameter int ITER_W    = CG_ITER_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        total,
    input  logic                     start,
    input  logic                     preload_done,
    input  logic [NUM_CH-1:0]        rd_adv,
    input  logic [NUM_CH-1:0]        wr_adv,
    input  logic                     iter_done,
    input  logic                     converged,
    output logic [ADDR_W-1:0]        a_rd_addr,
    output logic [NUM_CH*ADDR_W-1:0] rd_addr,
    output logic [NUM_CH*ADDR_W-1:0] wr_addr,
    output logic [NUM_CH-1:0]        wr_en,
    output logic [NUM_CH-1:0]        rd_wrap,
    output logic [NUM_CH-1:0]        wr_wrap,
    output logic [ITER_W-1:0]        iter_count,
    output logic                     busy,
    output logic                     halt
);

    localparam int                UNIT_SH   = $clog2(NUM_UNITS);
    localparam logic [ADDR_W-1:0] UNIT_MASK = ADDR_W'(NUM_UNITS - 1);
    localparam int                DRAIN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    cg_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   depth_q, depth_d;
    logic [ADDR_W-1:0]   a_rd_addr_q, a_rd_addr_d;
    logic [ITER_W-1:0]   iter_count_q, iter_count_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                clear_addr;

    logic [ADDR_W-1:0]   depth_quot;
    logic                depth_rem;
    logic [ADDR_W-1:0]   depth_calc;
    logic [ADDR_W-1:0]   depth_limit;
    logic [ADDR_W-1:0]   a_last;
    logic                run_active;

    // Vector depth in memory words: quotient by shift, round up when any
    // remainder bit is set, and never less than one word
    always_comb begin
        depth_quot = total >> UNIT_SH;
        depth_rem  = |(total & UNIT_MASK);
        depth_calc = depth_quot + ADDR_W'(depth_rem);
        if (depth_calc == '0) begin
            depth_calc = ADDR_W'(1);
        end
    end

    assign depth_limit = depth_q - ADDR_W'(1);
    assign a_last      = (depth_q << UNIT_SH) - ADDR_W'(1);
    assign run_active  = (state_q == ST_RUN);

    // Next-state logic; converged takes priority over every other transition
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        a_rd_addr_d  = a_rd_addr_q;
        iter_count_d = iter_count_q;
        drain_cnt_d  = drain_cnt_q;
        clear_addr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PRELOAD;
                    depth_d     = depth_calc;
                    a_rd_addr_d = '0;
                end
            end
            ST_PRELOAD: begin
                if (converged) begin
                    state_d = ST_HALT;
                end else if (preload_done) begin
                    state_d = ST_RUN;
                end else if (a_rd_addr_q < a_last) begin
                    a_rd_addr_d = a_rd_addr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (iter_done && (iter_count_q != '1)) begin
                    iter_count_d = iter_count_q + ITER_W'(1);
                end
                if (converged) begin
                    state_d = ST_HALT;
                end else if (iter_done) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                    clear_addr  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (converged) begin
                    state_d = ST_HALT;
                end else if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            depth_q      <= ADDR_W'(1);
            a_rd_addr_q  <= '0;
            iter_count_q <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            a_rd_addr_q  <= a_rd_addr_d;
            iter_count_q <= iter_count_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    // One read and one write address counter per channel
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            cg_wrap_counter #(
                .ADDR_W (ADDR_W)
            ) u_rd_cnt (
                .clk     (clk),
                .reset   (reset),
                .clear_i (clear_addr),
                .en_i    (run_active & rd_adv[gi]),
                .limit_i (depth_limit),
                .count_o (rd_addr[gi*ADDR_W +: ADDR_W]),
                .wrap_o  (rd_wrap[gi])
            );

            cg_wrap_counter #(
                .ADDR_W (ADDR_W)
            ) u_wr_cnt (
                .clk     (clk),
                .reset   (reset),
                .clear_i (clear_addr),
                .en_i    (run_active & wr_adv[gi]),
                .limit_i (depth_limit),
                .count_o (wr_addr[gi*ADDR_W +: ADDR_W]),
                .wrap_o  (wr_wrap[gi])
            );
        end
    endgenerate

    assign wr_en      = wr_adv & {NUM_CH{run_active}};
    assign a_rd_addr  = a_rd_addr_q;
    assign iter_count = iter_count_q;
    assign busy       = (state_q == ST_PRELOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign halt       = (state_q == ST_HALT);

endmodule : cg_addr_sequencer

// File: tb/tb_cg_addr_sequencer.sv
// Bench for cg_addr_sequencer: directed scenarios with literal expectations
// plus a per-cycle comparison against a counting model of the sequencer.
module tb_cg_addr_sequencer;

    localparam int NU = 8;
    localparam int NCH = 4;
    localparam int AW = 32;
    localparam int IW = 11;
    localparam int DRAIN_LEN = 4;
    localparam longint IMAX = (64'd1 << IW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_PRE = 1;
    localparam int M_RUN = 2;
    localparam int M_DRAIN = 3;
    localparam int M_HALT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [AW-1:0]     total = '0;
    logic              start = 1'b0;
    logic              preload_done = 1'b0;
    logic [NCH-1:0]    rd_adv = '0;
    logic [NCH-1:0]    wr_adv = '0;
    logic              iter_done = 1'b0;
    logic              converged = 1'b0;
    logic [AW-1:0]     a_rd_addr;
    logic [NCH*AW-1:0] rd_addr;
    logic [NCH*AW-1:0] wr_addr;
    logic [NCH-1:0]    wr_en;
    logic [NCH-1:0]    rd_wrap;
    logic [NCH-1:0]    wr_wrap;
    logic [IW-1:0]     iter_count;
    logic              busy;
    logic              halt;

    int checks = 0;
    int failures = 0;

    cg_addr_sequencer #(
        .NUM_UNITS (NU),
        .NUM_CH    (NCH),
        .ADDR_W    (AW),
        .ITER_W    (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .total        (total),
        .start        (start),
        .preload_done (preload_done),
        .rd_adv       (rd_adv),
        .wr_adv       (wr_adv),
        .iter_done    (iter_done),
        .converged    (converged),
        .a_rd_addr    (a_rd_addr),
        .rd_addr      (rd_addr),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .rd_wrap      (rd_wrap),
        .wr_wrap      (wr_wrap),
        .iter_count   (iter_count),
        .busy         (busy),
        .halt         (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rd_of(input int ch);
        return rd_addr[ch*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wr_of(input int ch);
        return wr_addr[ch*AW +: AW];
    endfunction

    // Model: addresses are the number of accepted strobes since the last
    // clear, taken modulo the vector depth
    int     m_mode = M_IDLE;
    longint m_d = 1;
    longint m_pre = 0;
    int     m_rd_n[NCH];
    int     m_wr_n[NCH];
    bit     m_rd_w[NCH];
    bit     m_wr_w[NCH];
    longint m_iter = 0;
    int     m_drain = 0;
    bit     m_valid = 0;

    initial begin
        longint a_exp;
        longint tt;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                a_exp = (m_pre < m_d * NU - 1) ? m_pre : m_d * NU - 1;
                chk("a_rd_addr", a_rd_addr, a_exp);
                chk("iter_count", iter_count, m_iter);
                chk("busy", busy, (m_mode == M_PRE || m_mode == M_RUN || m_mode == M_DRAIN));
                chk("halt", halt, m_mode == M_HALT);
                chk("wr_en", wr_en, (m_mode == M_RUN) ? wr_adv : '0);
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("rd_addr[%0d]", c), rd_of(c), m_rd_n[c] % m_d);
                    chk($sformatf("wr_addr[%0d]", c), wr_of(c), m_wr_n[c] % m_d);
                    chk($sformatf("rd_wrap[%0d]", c), rd_wrap[c], m_rd_w[c]);
                    chk($sformatf("wr_wrap[%0d]", c), wr_wrap[c], m_wr_w[c]);
                end
            end
            // Advance the model with the inputs the coming edge will sample
            if (reset) begin
                m_mode = M_IDLE;
                m_d = 1;
                m_pre = 0;
                m_iter = 0;
                m_drain = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_rd_n[c] = 0; m_wr_n[c] = 0; m_rd_w[c] = 0; m_wr_w[c] = 0;
                end
                m_valid = 1;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    m_rd_w[c] = 0; m_wr_w[c] = 0;
                end
                case (m_mode)
                    M_IDLE: if (start) begin
                        tt = longint'(total);
                        m_d = (tt + NU - 1) / NU;
                        if (m_d == 0) m_d = 1;
                        m_pre = 0;
                        m_mode = M_PRE;
                    end
                    M_PRE: begin
                        if (converged) m_mode = M_HALT;
                        else if (preload_done) m_mode = M_RUN;
                        else m_pre++;
                    end
                    M_RUN: begin
                        for (int c = 0; c < NCH; c++) begin
                            if (rd_adv[c]) begin
                                m_rd_n[c]++;
                                m_rd_w[c] = (m_rd_n[c] % m_d) == 0;
                            end
                            if (wr_adv[c]) begin
                                m_wr_n[c]++;
                                m_wr_w[c] = (m_wr_n[c] % m_d) == 0;
                            end
                        end
                        if (iter_done && m_iter < IMAX) m_iter++;
                        if (converged) begin
                            m_mode = M_HALT;
                        end else if (iter_done) begin
                            m_mode = M_DRAIN;
                            m_drain = DRAIN_LEN;
                            for (int c = 0; c < NCH; c++) begin
                                m_rd_n[c] = 0; m_wr_n[c] = 0; m_rd_w[c] = 0; m_wr_w[c] = 0;
                            end
                        end
                    end
                    M_DRAIN: begin
                        if (converged) begin
                            m_mode = M_HALT;
                        end else begin
                            m_drain--;
                            if (m_drain == 0) m_mode = M_RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd_seq[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        int wr_seq[4] = '{1, 2, 0, 1};

        // Reset state
        step(); step();
        reset = 1'b0;
        chk("reset a_rd_addr", a_rd_addr, 0);
        chk("reset iter_count", iter_count, 0);
        chk("reset busy", busy, 0);
        chk("reset halt", halt, 0);
        $display("reset released");

        // total=64 -> D=8; preload_done in the third PRELOAD cycle
        total = 64; start = 1'b1;
        step();
        start = 1'b0;
        chk("pre a0", a_rd_addr, 0);
        chk("pre busy", busy, 1);
        step();
        chk("pre a1", a_rd_addr, 1);
        step();
        chk("pre a2", a_rd_addr, 2);
        preload_done = 1'b1;
        step();
        preload_done = 1'b0;
        chk("run a hold", a_rd_addr, 2);
        step();
        chk("run a hold2", a_rd_addr, 2);
        $display("preload total=64 done, a_rd_addr=%0d", a_rd_addr);

        // Nine read advances on channel 0 with D=8
        rd_adv = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("rd0 seq %0d", k), rd_of(0), rd_seq[k]);
            chk($sformatf("rd0 wrap %0d", k), rd_wrap[0], k == 7);
            $display("rd_adv[0] #%0d rd_addr[0]=%0d rd_wrap[0]=%0b", k, rd_of(0), rd_wrap[0]);
        end
        rd_adv = '0;

        // iter_done mid-run: addresses cleared, strobes ignored while draining
        iter_done = 1'b1; rd_adv = '1; wr_adv = '1;
        step();
        iter_done = 1'b0;
        chk("drain rd0", rd_of(0), 0);
        chk("drain iter", iter_count, 1);
        chk("drain busy", busy, 1);
        chk("drain wr_en", wr_en, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("drain rd3 %0d", k), rd_of(3), 0);
            chk($sformatf("drain wr1 %0d", k), wr_of(1), 0);
        end
        step();
        chk("rerun rd0", rd_of(0), 0);
        chk("rerun wr_en", wr_en, 4'hF);
        step();
        chk("rerun rd3", rd_of(3), 1);
        chk("rerun wr1", wr_of(1), 1);
        rd_adv = '0; wr_adv = '0;
        $display("iteration drain done, iter_count=%0d", iter_count);

        // total=20 -> D=3; write pulses on channel 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        total = 20; start = 1'b1;
        step();
        start = 1'b0; preload_done = 1'b1;
        step();
        preload_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_adv = 4'b0100;
            #1;
            chk($sformatf("wr_en on %0d", k), wr_en, 4'b0100);
            step();
            wr_adv = '0;
            #1;
            chk($sformatf("wr_en off %0d", k), wr_en, 0);
            chk($sformatf("wr2 seq %0d", k), wr_of(2), wr_seq[k]);
            chk($sformatf("wr2 wrap %0d", k), wr_wrap[2], k == 2);
            $display("wr_adv[2] #%0d wr_addr[2]=%0d wr_wrap[2]=%0b", k, wr_of(2), wr_wrap[2]);
            step();
        end

        // converged together with iter_done: halt, count once, ignore start
        iter_done = 1'b1; converged = 1'b1;
        step();
        iter_done = 1'b0; converged = 1'b0;
        chk("halt flag", halt, 1);
        chk("halt busy", busy, 0);
        chk("halt iter", iter_count, 1);
        total = 8; start = 1'b1;
        step();
        start = 1'b0;
        chk("halt after start", halt, 1);
        wr_adv = '1;
        #1;
        chk("halt wr_en", wr_en, 0);
        wr_adv = '0;
        $display("converged: halt=%0b iter_count=%0d", halt, iter_count);

        // total=0 -> D=1: preload saturates at 7, every read advance wraps
        reset = 1'b1;
        step();
        reset = 1'b0;
        total = 0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("sat a_rd_addr", a_rd_addr, 7);
        preload_done = 1'b1;
        step();
        preload_done = 1'b0;
        rd_adv = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("d1 rd1 %0d", k), rd_of(1), 0);
            chk($sformatf("d1 wrap %0d", k), rd_wrap[1], 1);
        end
        $display("total=0 depth-1 run, a_rd_addr=%0d", a_rd_addr);

        // reset during RUN with all read strobes high
        rd_adv = '1; wr_adv = '1; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst rd1", rd_of(1), 0);
        chk("rst rd_wrap", rd_wrap, 0);
        chk("rst wr_wrap", wr_wrap, 0);
        chk("rst a_rd_addr", a_rd_addr, 0);
        chk("rst busy", busy, 0);
        chk("rst halt", halt, 0);
        chk("rst wr_en", wr_en, 0);
        step();
        chk("idle rd0", rd_of(0), 0);
        rd_adv = '0; wr_adv = '0;
        $display("reset during run done");
        step(); step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cg_addr_sequencer

// File: doc/cg_addr_sequencer.md
CG_ADDR_SEQUENCER -- requirements
Module: cg_addr_sequencer

Interface
REQ-001 Parameter NUM_UNITS, default 8, meaning elements per memory word (power of two, 1..64).
REQ-002 Parameter NUM_CH, default 4, meaning independent vector channels (P, Pv2, R, X; 1..8).
REQ-003 Parameter ADDR_W, default 32, meaning width of every address output and of total.
REQ-004 Parameter ITER_W, default 11, meaning iteration counter width.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 total  in  ADDR_W  vector length in elements; sampled only on start.
REQ-008 start  in  1  one-cycle pulse; begins a solve (accepted only in IDLE).
REQ-009 preload_done  in  1  A-matrix preprocessing finished.
REQ-010 rd_adv  in  NUM_CH  per-channel read-advance strobe.
REQ-011 wr_adv  in  NUM_CH  per-channel result-valid strobe.
REQ-012 iter_done  in  1  one-cycle pulse; ALU finished one CG iteration.
REQ-013 converged  in  1  one-cycle pulse; solver finished.
REQ-014 a_rd_addr  out  ADDR_W  A-memory read address.
REQ-015 rd_addr  out  NUM_CH*ADDR_W  packed per-channel read addresses, channel 0 in LSBs.
REQ-016 wr_addr  out  NUM_CH*ADDR_W  packed per-channel write addresses.
REQ-017 wr_en  out  NUM_CH  per-channel write enable.
REQ-018 rd_wrap / wr_wrap  out  NUM_CH each  one-cycle pulse on address wrap.
REQ-019 iter_count  out  ITER_W  completed iterations; busy, halt  out  1 each.

Function
REQ-020 Depth D SHALL be ceil(total/NUM_UNITS), computed by shift plus remainder-OR on start, registered.
REQ-021 States SHALL be IDLE, PRELOAD, RUN, DRAIN, HALT; IDLE->PRELOAD on start; PRELOAD->RUN on preload_done; RUN->DRAIN on iter_done; DRAIN->RUN after 4 cycles; any non-IDLE state->HALT on converged; HALT->IDLE only by reset.
REQ-022 In PRELOAD a_rd_addr SHALL increment by 1 per cycle from 0, saturating at D*NUM_UNITS-1; elsewhere it holds.
REQ-023 In RUN, rd_adv[i] SHALL increment rd_addr[i] next cycle; at D-1 it SHALL wrap to 0 and pulse rd_wrap[i] the same cycle the wrapped value appears.
REQ-024 wr_en[i] SHALL equal wr_adv[i] combinationally; wr_addr[i] SHALL advance the cycle after each wr_adv[i], wrapping at D-1 with wr_wrap[i].
REQ-025 Strobes outside RUN SHALL be ignored (no increment, wr_en forced 0).
REQ-026 Entering DRAIN SHALL zero all rd_addr/wr_addr and increment iter_count (saturating at all ones).
REQ-027 converged and iter_done in the same cycle: converged wins, iter_count still increments once.
REQ-028 start while not IDLE SHALL be ignored; total=0 SHALL give D=1.
REQ-029 busy SHALL be 1 in PRELOAD/RUN/DRAIN; halt SHALL be 1 only in HALT.

Reset
REQ-030 reset SHALL override all inputs and return state IDLE, all addresses 0, a_rd_addr 0, wr_en/wraps 0, iter_count 0, busy 0, halt 0, D 1.
REQ-031 reset mid-RUN SHALL discard in-flight strobes of that cycle.

Structure
REQ-032 State encoding, DRAIN_CYCLES=4 and default parameter values SHALL live in shared package cg_pkg.
REQ-033 One sub-module cg_wrap_counter (ADDR_W-wide counter: clear, enable, limit, wrap pulse) SHALL be instantiated 2*NUM_CH times.
REQ-034 No @(posedge) inside procedural blocks; no blocking assignment in sequential logic.

Verification
REQ-035 total=64, NUM_UNITS=8, start, preload_done after 3 cycles -> a_rd_addr 0,1,2 then holds; state RUN.
REQ-036 RUN, rd_adv[0] high 9 cycles, D=8 -> rd_addr[0] 1..7,0,1; rd_wrap[0] once, with value 0.
REQ-037 total=20, NUM_UNITS=8 -> D=3; wr_adv[2] 4 pulses -> wr_addr[2] 1,2,0,1; wr_en[2] mirrors strobes.
REQ-038 iter_done mid-run -> addresses 0, iter_count 1, strobes ignored 4 cycles, then RUN.
REQ-039 converged with iter_done -> HALT, halt=1, iter_count+1; later start ignored.
REQ-040 reset asserted during RUN with rd_adv=all ones -> next cycle every output at reset value.
